// File: rtl/player_anim_fsm.sv
// player_anim_fsm
//   Animation and motion controller for a 2D fighter sprite. Every state,
//   frame, divider and position update happens only on frame_tick cycles.
//   Each animation frame lasts TICKS_PER_FRAME ticks. IDLE and MOVE loop.
//   ATK1 and ATK2 are one-shots. HIT is hitstun, and another hit restarts it.
//
// Ports
//   clk, reset         : rising-edge clock, synchronous active-high reset
//   frame_tick         : one-cycle pulse per video frame (update enable)
//   btn_left/right     : movement requests (level)
//   btn_atk1/atk2      : attack requests (level)
//   hit                : damage request (level, sampled on frame_tick)
//   anim_state         : 0 IDLE, 1 MOVE, 3 ATK1, 4 ATK2, 5 HIT (the FSM state)
//   anim_frame         : frame index within anim_state
//   facing_right       : sprite orientation
//   pos_x              : sprite left edge in pixels
//   atk_active         : attack-1 hit window is on screen
//   busy               : in ATK1, ATK2 or HIT
//
// Handshake: there is no valid/ready pair. frame_tick is a qualifier only.
// Inputs are sampled on the rising edge where frame_tick=1, and the outputs
// hold between ticks.
module player_anim_fsm #(
  parameter int TICKS_PER_FRAME = 4,
  parameter int IDLE_FRAMES     = 10,
  parameter int RUN_FRAMES      = 8,
  parameter int ATK1_FRAMES     = 18,
  parameter int ATK2_FRAMES     = 12,
  parameter int HIT_FRAMES      = 4,
  parameter int MOVE_STEP       = 2,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 514,
  parameter int X_INIT          = 100,
  parameter int ATK1_ACT_LO     = 8,
  parameter int ATK1_ACT_HI     = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_atk1,
  input  logic       btn_atk2,
  input  logic       hit,
  output logic [3:0] anim_state,
  output logic [5:0] anim_frame,
  output logic       facing_right,
  output logic [9:0] pos_x,
  output logic       atk_active,
  output logic       busy
);

  localparam int DIV_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICKS_PER_FRAME - 1);
  localparam logic [10:0] X_MIN_W  = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W  = 11'(X_MAX);
  localparam logic [10:0] STEP_W   = 11'(MOVE_STEP);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_MOVE = 4'd1,
    ST_ATK1 = 4'd3,
    ST_ATK2 = 4'd4,
    ST_HIT  = 4'd5
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       frame_q, frame_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             facing_q, facing_d;
  logic [9:0]       pos_q, pos_d;

  state_e     req;
  logic [5:0] frame_len;
  logic       frame_done;
  logic       last_frame;
  logic       restart;
  logic [10:0] pos_ext;

  // Request arbitration used from IDLE/MOVE and at the end of a one-shot.
  // Both movement buttons pressed together means no move.
  always_comb begin
    req = ST_IDLE;
    if (hit)                       req = ST_HIT;
    else if (btn_atk1)             req = ST_ATK1;
    else if (btn_atk2)             req = ST_ATK2;
    else if (btn_left ^ btn_right) req = ST_MOVE;
  end

  always_comb begin
    frame_len = 6'(IDLE_FRAMES);
    case (state_q)
      ST_MOVE: frame_len = 6'(RUN_FRAMES);
      ST_ATK1: frame_len = 6'(ATK1_FRAMES);
      ST_ATK2: frame_len = 6'(ATK2_FRAMES);
      ST_HIT:  frame_len = 6'(HIT_FRAMES);
      default: frame_len = 6'(IDLE_FRAMES);
    endcase
  end

  assign frame_done = (div_q == DIV_LAST);
  assign last_frame = (frame_q == frame_len - 6'd1);
  assign pos_ext    = {1'b0, pos_q};

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    div_d    = div_q;
    facing_d = facing_q;
    pos_d    = pos_q;
    restart  = 1'b0;

    if (frame_tick) begin
      case (state_q)
        ST_IDLE, ST_MOVE: begin
          state_d = req;
          restart = (req != state_q);
        end
        ST_ATK1, ST_ATK2, ST_HIT: begin
          // A hit aborts an attack, and it also re-arms hitstun from frame 0.
          // Otherwise the one-shot runs to the end of its last frame and then
          // re-arbitrates. A held attack button therefore replays the attack.
          if (hit) begin
            state_d = ST_HIT;
            restart = 1'b1;
          end else if (frame_done && last_frame) begin
            state_d = req;
            restart = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          restart = 1'b1;
        end
      endcase

      if (restart) begin
        frame_d = 6'd0;
        div_d   = '0;
      end else if (frame_done) begin
        div_d   = '0;
        frame_d = last_frame ? 6'd0 : frame_q + 6'd1;
      end else begin
        div_d   = div_q + 1'b1;
      end

      // Motion and facing follow the state this tick ends in. MOVE implies
      // that exactly one direction button is pressed.
      if (state_d == ST_MOVE) begin
        facing_d = btn_right;
        if (btn_right) begin
          pos_d = (pos_ext + STEP_W > X_MAX_W) ? 10'(X_MAX) : 10'(pos_ext + STEP_W);
        end else begin
          pos_d = (pos_ext < X_MIN_W + STEP_W) ? 10'(X_MIN) : 10'(pos_ext - STEP_W);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      frame_q  <= 6'd0;
      div_q    <= '0;
      facing_q <= 1'b1;
      pos_q    <= 10'(X_INIT);
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      div_q    <= div_d;
      facing_q <= facing_d;
      pos_q    <= pos_d;
    end
  end

  assign anim_state   = state_q;
  assign anim_frame   = frame_q;
  assign facing_right = facing_q;
  assign pos_x        = pos_q;
  assign atk_active   = (state_q == ST_ATK1) &&
                        (frame_q >= 6'(ATK1_ACT_LO)) && (frame_q <= 6'(ATK1_ACT_HI));
  assign busy         = (state_q == ST_ATK1) || (state_q == ST_ATK2) || (state_q == ST_HIT);

endmodule

// File: tb/tb_player_anim_fsm.sv
// tb_player_anim_fsm
//   Bench for player_anim_fsm. It runs directed scenarios with literal
//   expectations and then a randomized soak. The reference model describes
//   each state by its tick count since entry, and it derives frame indices
//   and one-shot completion arithmetically from that count.
module tb_player_anim_fsm;

  localparam int TPF     = 4;
  localparam int IDLE_F  = 10;
  localparam int RUN_F   = 8;
  localparam int ATK1_F  = 18;
  localparam int ATK2_F  = 12;
  localparam int HIT_F   = 4;
  localparam int STEP    = 2;
  localparam int XMIN    = 0;
  localparam int XMAX    = 514;
  localparam int XINIT   = 100;
  localparam int ACT_LO  = 8;
  localparam int ACT_HI  = 11;

  localparam int S_IDLE = 0, S_MOVE = 1, S_ATK1 = 3, S_ATK2 = 4, S_HIT = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_atk1 = 1'b0, btn_atk2 = 1'b0, hit = 1'b0;
  logic [3:0] anim_state;
  logic [5:0] anim_frame;
  logic       facing_right;
  logic [9:0] pos_x;
  logic       atk_active;
  logic       busy;

  always #5 clk = ~clk;

  player_anim_fsm dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right),
    .btn_atk1(btn_atk1), .btn_atk2(btn_atk2), .hit(hit),
    .anim_state(anim_state), .anim_frame(anim_frame),
    .facing_right(facing_right), .pos_x(pos_x),
    .atk_active(atk_active), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_state = S_IDLE;
  int m_t     = 0;     // ticks spent in the current state since entry
  int m_pos   = XINIT;
  bit m_face  = 1'b1;
  bit m_valid = 1'b0;

  function automatic int shot_len(input int st);
    case (st)
      S_ATK1:  return ATK1_F;
      S_ATK2:  return ATK2_F;
      default: return HIT_F;
    endcase
  endfunction

  function automatic int m_frame(input int st, input int t);
    if (st == S_IDLE) return (t / TPF) % IDLE_F;
    if (st == S_MOVE) return (t / TPF) % RUN_F;
    return t / TPF;
  endfunction

  always @(posedge clk) begin
    automatic int req;
    automatic int nst;
    automatic int nt;
    if (reset) begin
      m_state <= S_IDLE; m_t <= 0; m_pos <= XINIT; m_face <= 1'b1; m_valid <= 1'b1;
    end else if (frame_tick) begin
      if (hit) req = S_HIT;
      else if (btn_atk1) req = S_ATK1;
      else if (btn_atk2) req = S_ATK2;
      else if (btn_left != btn_right) req = S_MOVE;
      else req = S_IDLE;
      nst = m_state;
      nt  = m_t + 1;
      if (m_state == S_IDLE || m_state == S_MOVE) begin
        nst = req;
        if (req != m_state) nt = 0;
      end else if (hit) begin
        nst = S_HIT; nt = 0;
      end else if (m_t + 1 == shot_len(m_state) * TPF) begin
        nst = req; nt = 0;
      end
      m_state <= nst;
      m_t     <= nt;
      if (nst == S_MOVE) begin
        m_face <= btn_right;
        m_pos  <= btn_right ? ((m_pos + STEP > XMAX) ? XMAX : m_pos + STEP)
                            : ((m_pos - STEP < XMIN) ? XMIN : m_pos - STEP);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("state", int'(anim_state), m_state);
      check("frame", int'(anim_frame), m_frame(m_state, m_t));
      check("facing", int'(facing_right), int'(m_face));
      check("pos_x", int'(pos_x), m_pos);
      check("atk_active", int'(atk_active),
            int'(m_state == S_ATK1 && m_frame(m_state, m_t) >= ACT_LO &&
                 m_frame(m_state, m_t) <= ACT_HI));
      check("busy", int'(busy), int'(m_state == S_ATK1 || m_state == S_ATK2 || m_state == S_HIT));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic set_btn(input bit l, input bit r, input bit a1, input bit a2, input bit h);
    btn_left = l; btn_right = r; btn_atk1 = a1; btn_atk2 = a2; hit = h;
  endtask

  // One frame_tick with the current buttons, followed by 0..2 idle cycles.
  task automatic tick();
    int gap;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    gap = $urandom_range(0, 2);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  initial begin
    int exp_left[5];
    exp_left = '{2, 0, 0, 0, 0};

    do_reset();
    check("reset_state", int'(anim_state), S_IDLE);
    check("reset_pos", int'(pos_x), XINIT);
    check("reset_facing", int'(facing_right), 1);
    check("reset_busy", int'(busy), 0);

    // Hold right for 40 ticks.
    set_btn(0, 1, 0, 0, 0);
    repeat (40) tick();
    check("run_state", int'(anim_state), S_MOVE);
    check("run_pos", int'(pos_x), 180);
    check("run_frame", int'(anim_frame), 1);
    check("run_facing", int'(facing_right), 1);

    // Walk left down to 4, then into the left wall.
    set_btn(1, 0, 0, 0, 0);
    repeat (88) tick();
    check("left_pos4", int'(pos_x), 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("left_sat", int'(pos_x), exp_left[i]);
    end
    check("left_facing", int'(facing_right), 0);

    // Attack-1 single-tick pulse from IDLE.
    do_reset();
    set_btn(0, 0, 1, 0, 0);
    tick();
    set_btn(0, 0, 0, 0, 0);
    check("atk1_enter", int'(anim_state), S_ATK1);
    for (int k = 1; k < 72; k++) begin
      tick();
      check("atk1_hold", int'(anim_state), S_ATK1);
      check("atk1_window", int'(atk_active), int'(k >= 32 && k <= 47));
    end
    tick();
    check("atk1_done_state", int'(anim_state), S_IDLE);
    check("atk1_done_frame", int'(anim_frame), 0);

    // Hit wins over both attacks in MOVE, then a hit re-arms HIT.
    do_reset();
    set_btn(0, 1, 0, 0, 0);
    repeat (3) tick();
    set_btn(0, 1, 1, 1, 1);
    tick();
    check("hit_prio", int'(anim_state), S_HIT);
    set_btn(0, 0, 0, 0, 0);
    repeat (8) tick();
    check("hit_frame2", int'(anim_frame), 2);
    set_btn(0, 0, 0, 0, 1);
    tick();
    check("hit_restart_state", int'(anim_state), S_HIT);
    check("hit_restart_frame", int'(anim_frame), 0);

    // Both directions pressed means IDLE with no motion. With no ticks, nothing moves.
    do_reset();
    set_btn(0, 1, 0, 0, 0);
    repeat (3) tick();
    set_btn(1, 0, 0, 0, 0);
    repeat (2) tick();
    set_btn(1, 1, 0, 0, 0);
    tick();
    check("both_state", int'(anim_state), S_IDLE);
    check("both_pos", int'(pos_x), 102);
    check("both_facing", int'(facing_right), 0);
    for (int c = 0; c < 100; c++) begin
      set_btn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk); #1;
    end
    check("notick_state", int'(anim_state), S_IDLE);
    check("notick_pos", int'(pos_x), 102);
    check("notick_frame", int'(anim_frame), 0);

    // Reset during ATK2 frame 6.
    do_reset();
    set_btn(1, 0, 0, 0, 0);
    repeat (3) tick();
    set_btn(0, 0, 0, 1, 0);
    tick();
    set_btn(0, 0, 0, 0, 0);
    repeat (24) tick();
    check("atk2_frame6", int'(anim_frame), 6);
    check("atk2_state", int'(anim_state), S_ATK2);
    frame_tick = 1'b1;
    do_reset();
    frame_tick = 1'b0;
    check("rst_state", int'(anim_state), S_IDLE);
    check("rst_pos", int'(pos_x), 100);
    check("rst_facing", int'(facing_right), 1);
    check("rst_busy", int'(busy), 0);

    // Randomized soak.
    for (int n = 0; n < 3000; n++) begin
      set_btn($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 40,
              $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 5,
              $urandom_range(0, 99) < 4);
      if ($urandom_range(0, 199) == 0) do_reset();
      tick();
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
